// File: rtl/mont_mul_unit_if.sv
// Request/response bundle between a point-arithmetic controller (master) and the
// Montgomery multiplier (slave): en request level, operands in, result and done pulse out.
interface mont_mul_unit_if #(
  parameter int WIDTH = 256
);
  logic             en;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] x1;
  logic             sign;

  modport master (output en, x0, y0, input x1, sign);
  modport slave  (input en, x0, y0, output x1, sign);
endinterface

// File: rtl/mont_mul_unit.sv
// Bit-serial radix-2 Montgomery multiplier: x1 = x0*y0*2^-WIDTH mod P, one operand bit per cycle.
// Starts on a rising edge of en seen in IDLE; sign pulses WIDTH+2 cycles after the start edge.
module mont_mul_unit #(
  parameter int               WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = 256'hB6400000_02A3A6F1_D603AB4F_F58EC745_21F2934B_1A7AEEDB_E56F9B27_E351457D
) (
  input  logic             clk,
  input  logic             rst,
  mont_mul_unit_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic             sign_q, sign_d;
  logic [WIDTH+1:0] t_sum;
  logic [WIDTH+1:0] t_red;

  always_comb begin
    state_d = state_q;
    en_d    = bus.en;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    x1_d    = x1_q;
    sign_d  = sign_q;
    t_sum   = '0;
    t_red   = '0;

    case (state_q)
      IDLE: begin
        if (bus.en && !en_q) begin
          a_d     = bus.x0;
          b_d     = bus.y0;
          s_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // S stays below 2P, so S + B + P never exceeds WIDTH+2 bits.
        t_sum   = {1'b0, s_q} + (a_q[cnt_q] ? {2'b00, b_q} : '0);
        t_red   = t_sum[0] ? (t_sum + {2'b00, P}) : t_sum;
        s_d     = t_red[WIDTH+1:1];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = FIN;
        end
      end
      FIN: begin
        // When S >= P the difference is below P, so modulo-2^WIDTH subtraction is exact.
        x1_d    = (s_q >= {1'b0, P}) ? (s_q[WIDTH-1:0] - P) : s_q[WIDTH-1:0];
        sign_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        sign_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      x1_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      x1_q    <= x1_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.x1   = x1_q;
  assign bus.sign = sign_q;

endmodule

// File: tb/tb_mont_mul_unit.sv
// Directed bench: an 8-bit instance (P=251) for quick arithmetic and handshake cases,
// plus a default 256-bit SM9 instance for identity, zero, long-hold and reset cases.
module tb_mont_mul_unit;

  localparam logic [255:0] P256  = 256'hB6400000_02A3A6F1_D603AB4F_F58EC745_21F2934B_1A7AEEDB_E56F9B27_E351457D;
  localparam logic [255:0] R_MOD = 256'h49BFFFFF_FD5C590E_29FC54B0_0A7138BA_DE0D6CB4_E5851124_1A9064D8_1CAEBA83;
  localparam logic [255:0] PM1   = 256'hB6400000_02A3A6F1_D603AB4F_F58EC745_21F2934B_1A7AEEDB_E56F9B27_E351457C;
  localparam logic [255:0] Y_A   = 256'h12345678_9ABCDEF0_0FEDCBA9_87654321_11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [255:0] Y_B   = 256'h0A5A5A5A_C3C3C3C3_0F0F0F0F_12121212_76543210_FEDCBA98_01234567_89ABCDEF;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mont_mul_unit_if #(.WIDTH(8))   bus8 ();
  mont_mul_unit_if #(.WIDTH(256)) bus  ();

  mont_mul_unit #(.WIDTH(8), .P(8'd251)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  mont_mul_unit #(.WIDTH(256), .P(P256)) u_dut  (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge; leaves en low for one cycle afterwards.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    int lat;
    lat = -1;
    bus8.x0 = a;
    bus8.y0 = b;
    bus8.en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus8.sign) begin
        lat = i - 1;
        break;
      end
    end
    check({tag, "_lat"}, 256'(lat), 256'd9);
    check({tag, "_x1"}, 256'(bus8.x1), 256'(exp));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 256'(bus8.sign), 256'd0);
    bus8.en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run256(input string tag, input logic [255:0] a, input logic [255:0] b, input logic [255:0] exp);
    int lat;
    lat = -1;
    bus.x0 = a;
    bus.y0 = b;
    bus.en = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (bus.sign) begin
        lat = i - 1;
        break;
      end
    end
    check({tag, "_lat"}, 256'(lat), 256'd257);
    check({tag, "_x1"}, bus.x1, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 256'(bus.sign), 256'd0);
    bus.en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;
    logic [255:0] x1_at_pulse;

    rst = 1'b1;
    bus8.en = 1'b0; bus8.x0 = '0; bus8.y0 = '0;
    bus.en  = 1'b0; bus.x0  = '0; bus.y0  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_x1_8",    256'(bus8.x1),   256'd0);
    check("rst_sign_8",  256'(bus8.sign), 256'd0);
    check("rst_x1_256",  bus.x1,          256'd0);
    check("rst_sign_256", 256'(bus.sign), 256'd0);
    @(posedge clk); #1;

    // 8-bit arithmetic: R = 256, R mod 251 = 5, R^-1 mod 251 = 201.
    run8("w8_10x20",   8'd10,  8'd20,  8'd40);
    run8("w8_250x250", 8'd250, 8'd250, 8'd201);
    run8("w8_5x123",   8'd5,   8'd123, 8'd123);

    // en toggled mid-CALC and operand changed after start: one pulse, original operands used.
    bus8.x0 = 8'd10; bus8.y0 = 8'd20; bus8.en = 1'b1;
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; end
    bus8.x0 = 8'd0;
    bus8.en = 1'b0;
    @(posedge clk); #1;
    bus8.en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus8.sign) pulses++;
    end
    check("w8_toggle_pulses", 256'(pulses), 256'd1);
    check("w8_toggle_x1", 256'(bus8.x1), 256'd40);
    bus8.en = 1'b0;
    @(posedge clk); #1;
    // 1*5*201 = 1005 = 4*251 + 1
    run8("w8_restart", 8'd1, 8'd5, 8'd1);

    // 256-bit: multiplying by R mod P is the identity.
    run256("w256_id",   R_MOD, Y_A, Y_A);
    run256("w256_pm1",  R_MOD, PM1, PM1);
    run256("w256_zero", 256'd0, Y_A, 256'd0);

    // en held high for 600 cycles.
    bus.x0 = R_MOD; bus.y0 = Y_B; bus.en = 1'b1;
    pulses = 0;
    x1_at_pulse = '0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (bus.sign) begin
        pulses++;
        x1_at_pulse = bus.x1;
      end
    end
    check("hold_pulses", 256'(pulses), 256'd1);
    check("hold_x1_at_pulse", x1_at_pulse, Y_B);
    check("hold_x1_stable", bus.x1, Y_B);
    bus.en = 1'b0;
    @(posedge clk); #1;

    // Reset 100 cycles into an operation with en held high.
    bus.x0 = R_MOD; bus.y0 = Y_A; bus.en = 1'b1;
    repeat (100) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_x1", bus.x1, 256'd0);
    check("mid_rst_sign", 256'(bus.sign), 256'd0);
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus.sign) pulses++;
    end
    check("mid_rst_no_pulse", 256'(pulses), 256'd0);
    check("mid_rst_x1_held", bus.x1, 256'd0);
    bus.en = 1'b0;
    @(posedge clk); #1;
    run256("w256_after_rst", R_MOD, Y_B, Y_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
